// File: rtl/debug_word_tx_pkg.sv
// Shared debug-unit definitions: FSM state encoding, default UART byte width
// and the byte-count helpers used to size the word framer.
package debug_word_tx_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_STATE        = 3;

  localparam logic [NB_STATE-1:0] ST_IDLE  = 3'd0;
  localparam logic [NB_STATE-1:0] ST_START = 3'd1;
  localparam logic [NB_STATE-1:0] ST_WAIT  = 3'd2;
  localparam logic [NB_STATE-1:0] ST_CHK   = 3'd3;
  localparam logic [NB_STATE-1:0] ST_DONE  = 3'd4;

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_CHK   = ST_CHK,
    S_DONE  = ST_DONE
  } state_t;

  function automatic int byte_count(input int nb_word, input int nb_data);
    return nb_word / nb_data;
  endfunction

  // A single-byte word still needs a 1-bit counter.
  function automatic int count_width(input int nb_bytes);
    return (nb_bytes > 1) ? $clog2(nb_bytes) : 1;
  endfunction

endpackage

// File: rtl/debug_word_tx_if.sv
// Word handshake plus UART transmit-side signals between the debug unit,
// the word framer and the UART transmitter.
interface debug_word_tx_if #(
  parameter int NB_DATA = debug_word_tx_pkg::NB_DATA_DEFAULT,
  parameter int NB_WORD = 32
);

  logic [NB_WORD-1:0] i_word;
  logic               i_word_valid;
  logic               o_word_ready;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done_tick;
  logic               o_busy;
  logic               o_word_done_tick;

  modport master (
    output i_word,
    output i_word_valid,
    input  o_word_ready,
    input  o_tx_data,
    input  o_tx_start,
    output i_tx_done_tick,
    input  o_busy,
    input  o_word_done_tick
  );

  modport slave (
    input  i_word,
    input  i_word_valid,
    output o_word_ready,
    output o_tx_data,
    output o_tx_start,
    input  i_tx_done_tick,
    output o_busy,
    output o_word_done_tick
  );

endinterface

// File: rtl/debug_word_tx.sv
// Debug-unit word framer: sends one wide word LSB-first as UART bytes.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module debug_word_tx #(
  parameter int NB_DATA = debug_word_tx_pkg::NB_DATA_DEFAULT,
  parameter int NB_WORD = 32
) (
  input logic            i_clock,
  input logic            i_reset,
  debug_word_tx_if.slave bus
);
  import debug_word_tx_pkg::*;

  localparam int                NB_BYTES  = byte_count(NB_WORD, NB_DATA);
  localparam int                NB_CNT    = count_width(NB_BYTES);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);

  state_t             state;
  logic [NB_WORD-1:0] shift_reg;
  logic [NB_WORD-1:0] shift_next;
  logic [NB_CNT-1:0]  byte_cnt;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               word_done_tick;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [NB_DATA-1:0] checksum;
`endif

  assign shift_next = shift_reg >> NB_DATA;

  // tx_data is loaded together with each start pulse so it stays stable
  // for the whole byte, including the checksum byte.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state          <= S_IDLE;
      shift_reg      <= '0;
      byte_cnt       <= '0;
      tx_data        <= '0;
      tx_start       <= 1'b0;
      word_done_tick <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      tx_start       <= 1'b0;
      word_done_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_word_valid) begin
            shift_reg <= bus.i_word;
            byte_cnt  <= '0;
            tx_data   <= bus.i_word[NB_DATA-1:0];
            tx_start  <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
            checksum  <= bus.i_word[NB_DATA-1:0];
`endif
            state     <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_tx_done_tick) begin
            if (byte_cnt != LAST_BYTE) begin
              shift_reg <= shift_next;
              byte_cnt  <= byte_cnt + 1'b1;
              tx_data   <= shift_next[NB_DATA-1:0];
              tx_start  <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
              checksum  <= checksum ^ shift_next[NB_DATA-1:0];
`endif
              state     <= S_START;
            end else begin
`ifdef DEBUG_TX_CHECKSUM_EN
              tx_data  <= checksum;
              tx_start <= 1'b1;
              state    <= S_CHK;
`else
              word_done_tick <= 1'b1;
              state          <= S_DONE;
`endif
            end
          end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        // The first CHK cycle carries the start pulse; a tick there is stale.
        S_CHK: begin
          if (bus.i_tx_done_tick && !tx_start) begin
            word_done_tick <= 1'b1;
            state          <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx_data        = tx_data;
  assign bus.o_tx_start       = tx_start;
  assign bus.o_word_done_tick = word_done_tick;
  assign bus.o_word_ready     = (state == S_IDLE);
  assign bus.o_busy           = (state != S_IDLE);

endmodule

// File: tb/tb_debug_word_tx.sv
// Directed bench for debug_word_tx with a UART model that answers each start
// pulse with a done tick about 20 cycles later.
module tb_debug_word_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic model_tick = 1'b0;
  logic spur_tick  = 1'b0;
  int   countdown  = 0;
  int   cyc        = 0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got[$];
  int         start_cyc[$];
  logic       prev_start = 1'b0;
  int         wide_cnt   = 0;
  int         done_cnt   = 0;
  int         done_cyc   = 0;
  int         tick_cyc   = 0;
  int         accept_cnt = 0;
  int         accept_cyc = 0;

  debug_word_tx_if #(.NB_DATA(8), .NB_WORD(32)) bus ();

  debug_word_tx #(.NB_DATA(8), .NB_WORD(32)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  assign bus.i_tx_done_tick = model_tick | spur_tick;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: tick is registered, so it is stable for a whole period.
  always @(posedge clk) begin
    model_tick <= 1'b0;
    if (countdown == 1) model_tick <= 1'b1;
    if (bus.o_tx_start) countdown <= 20;
    else if (countdown > 0) countdown <= countdown - 1;
  end

  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      got.push_back(bus.o_tx_data);
      start_cyc.push_back(cyc);
      if (prev_start) wide_cnt <= wide_cnt + 1;
    end
    prev_start <= bus.o_tx_start;
    if (model_tick) tick_cyc <= cyc;
    if (bus.o_word_done_tick) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rst_n && bus.i_word_valid && bus.o_word_ready) begin
      accept_cnt <= accept_cnt + 1;
      accept_cyc <= cyc;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.o_word_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      bus.i_word       = w;
      bus.i_word_valid = 1'b1;
      @(posedge clk); #1;
      bus.i_word_valid = 1'b0;
      bus.i_word       = 32'h5A5A_5A5A;
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_assert++;
      if ({bus.o_tx_start, bus.o_tx_data, bus.o_word_done_tick, bus.o_busy} !== 11'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cycle %0d: got start=%b data=%h done=%b busy=%b expected all 0",
                 i, bus.o_tx_start, bus.o_tx_data, bus.o_word_done_tick, bus.o_busy);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (bus.o_word_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0",
               bus.o_word_ready, bus.o_busy);
    end
  endtask

  task automatic test_single_word;
    logic [7:0] exp[$];
    int  b0, d0, w0;
    bit  ok;
    exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef DEBUG_TX_CHECKSUM_EN
    exp.push_back(8'h22);
`endif
    b0 = got.size(); d0 = done_cnt; w0 = wide_cnt;
    send_word(32'hDEADBEEF, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("[TB] FAIL single_accept: got timeout expected ready"); end
    wait_done(d0 + 1, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("[TB] FAIL single_done: got timeout expected word_done_tick"); end
    n_assert++;
    if (got.size() - b0 != exp.size()) begin
      n_fail++;
      $display("[TB] FAIL single_start_count: got %0d expected %0d", got.size() - b0, exp.size());
    end
    for (int i = 0; i < exp.size() && b0 + i < got.size(); i++) begin
      n_assert++;
      if (got[b0+i] !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL single_byte%0d: got %h expected %h", i, got[b0+i], exp[i]);
      end
    end
    n_assert++;
    if (wide_cnt != w0) begin
      n_fail++;
      $display("[TB] FAIL single_pulse_width: got %0d wide pulses expected 0", wide_cnt - w0);
    end
    if (got.size() > b0 + 1) begin
      n_assert++;
      if (start_cyc[b0] != accept_cyc + 1) begin
        n_fail++;
        $display("[TB] FAIL single_accept_latency: got start at %0d expected %0d", start_cyc[b0], accept_cyc + 1);
      end
      n_assert++;
      if (start_cyc[b0+1] - start_cyc[b0] != 22) begin
        n_fail++;
        $display("[TB] FAIL single_tick_latency: got spacing %0d expected 22", start_cyc[b0+1] - start_cyc[b0]);
      end
    end
    n_assert++;
    if (done_cyc != tick_cyc + 1) begin
      n_fail++;
      $display("[TB] FAIL single_done_latency: got %0d expected %0d", done_cyc, tick_cyc + 1);
    end
    n_assert++;
    if (bus.o_word_ready !== 1'b1 || bus.o_word_done_tick !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_after_done: got ready=%b done=%b busy=%b expected 1 0 0",
               bus.o_word_ready, bus.o_word_done_tick, bus.o_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[$];
    int  b0, d0, a0, first_done;
    bit  ok;
`ifdef DEBUG_TX_CHECKSUM_EN
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
`else
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
`endif
    b0 = got.size(); d0 = done_cnt; a0 = accept_cnt;
    bus.i_word       = 32'h0000_0001;
    bus.i_word_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (accept_cnt > a0) ok = 1'b1;
    end
    bus.i_word = 32'h8000_0000;
    wait_done(d0 + 1, ok);
    first_done = done_cyc;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (accept_cnt > a0 + 1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    bus.i_word_valid = 1'b0;
    n_assert++;
    if (!ok || accept_cyc != first_done + 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_accept: got accept at %0d expected %0d", accept_cyc, first_done + 1);
    end
    wait_done(d0 + 2, ok);
    n_assert++;
    if (!ok || got.size() - b0 != exp.size()) begin
      n_fail++;
      $display("[TB] FAIL b2b_byte_count: got %0d expected %0d", got.size() - b0, exp.size());
    end
    for (int i = 0; i < exp.size() && b0 + i < got.size(); i++) begin
      n_assert++;
      if (got[b0+i] !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, got[b0+i], exp[i]);
      end
    end
  endtask

  task automatic test_spurious_tick;
    logic [7:0] exp[$];
    int  b0, d0;
    bit  ok;
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
`ifdef DEBUG_TX_CHECKSUM_EN
    exp.push_back(8'h08);
`endif
    b0 = got.size(); d0 = done_cnt;
    wait_cycles(25);
    spur_tick = 1'b1;
    wait_cycles(3);
    spur_tick = 1'b0;
    n_assert++;
    if (bus.o_busy !== 1'b0 || bus.o_word_ready !== 1'b1 || got.size() != b0) begin
      n_fail++;
      $display("[TB] FAIL spur_idle: got busy=%b ready=%b starts=%0d expected 0 1 0",
               bus.o_busy, bus.o_word_ready, got.size() - b0);
    end
    bus.i_word       = 32'h1234_5678;
    bus.i_word_valid = 1'b1;
    spur_tick        = 1'b1;
    @(posedge clk); #1;
    bus.i_word_valid = 1'b0;
    n_assert++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h78) begin
      n_fail++;
      $display("[TB] FAIL spur_start_cycle: got start=%b data=%h expected 1 78", bus.o_tx_start, bus.o_tx_data);
    end
    @(posedge clk); #1;
    spur_tick = 1'b0;
    n_assert++;
    if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL spur_after_start: got start=%b busy=%b expected 0 1", bus.o_tx_start, bus.o_busy);
    end
    wait_done(d0 + 1, ok);
    n_assert++;
    if (!ok || got.size() - b0 != exp.size()) begin
      n_fail++;
      $display("[TB] FAIL spur_byte_count: got %0d expected %0d", got.size() - b0, exp.size());
    end
    for (int i = 0; i < exp.size() && b0 + i < got.size(); i++) begin
      n_assert++;
      if (got[b0+i] !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL spur_byte%0d: got %h expected %h", i, got[b0+i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] exp_first[$];
    logic [7:0] exp[$];
    int  b0, b1, d0;
    bit  ok;
    exp_first = '{8'h0D, 8'hF0, 8'hFE};
    exp = '{8'hEE, 8'hFF, 8'hC0, 8'h00};
`ifdef DEBUG_TX_CHECKSUM_EN
    exp.push_back(8'hD1);
`endif
    b0 = got.size();
    send_word(32'hCAFE_F00D, ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (got.size() >= b0 + 3) ok = 1'b1;
    end
    wait_cycles(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (bus.o_busy !== 1'b0 || bus.o_word_ready !== 1'b1 || bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midreset_state: got busy=%b ready=%b start=%b data=%h expected 0 1 0 00",
               bus.o_busy, bus.o_word_ready, bus.o_tx_start, bus.o_tx_data);
    end
    rst_n = 1'b1;
    wait_cycles(40);
    n_assert++;
    if (got.size() != b0 + 3 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_no_restart: got starts=%0d busy=%b expected 3 0", got.size() - b0, bus.o_busy);
    end
    for (int i = 0; i < 3 && b0 + i < got.size(); i++) begin
      n_assert++;
      if (got[b0+i] !== exp_first[i]) begin
        n_fail++;
        $display("[TB] FAIL midreset_byte%0d: got %h expected %h", i, got[b0+i], exp_first[i]);
      end
    end
    b1 = got.size(); d0 = done_cnt;
    send_word(32'h00C0_FFEE, ok);
    wait_done(d0 + 1, ok);
    n_assert++;
    if (!ok || got.size() - b1 != exp.size()) begin
      n_fail++;
      $display("[TB] FAIL midreset_new_count: got %0d expected %0d", got.size() - b1, exp.size());
    end
    for (int i = 0; i < exp.size() && b1 + i < got.size(); i++) begin
      n_assert++;
      if (got[b1+i] !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL midreset_new_byte%0d: got %h expected %h", i, got[b1+i], exp[i]);
      end
    end
  endtask

  initial begin
    bus.i_word       = '0;
    bus.i_word_valid = 1'b0;
    $display("[TB] debug_word_tx directed test start");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_spurious_tick();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
